// File: rtl/fetch_decode_pkg.sv
// Shared types for the fetch/decode boundary:
// occupancy state, NOP word and the buffered entry.
package fetch_decode_pkg;

  localparam int ENTRY_W = 32;

  localparam logic [ENTRY_W-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  typedef struct packed {
    logic [ENTRY_W-1:0] instr;
    logic [ENTRY_W-1:0] pc;
    logic [ENTRY_W-1:0] pc_plus4;
  } entry_t;

endpackage

// File: rtl/fetch_decode_skid_if_entry_reg.sv
// One load-enabled {instr, pc, pc+4} register.
// Used for both the head and the skid slot.
module if_entry_reg
  import fetch_decode_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  entry_t d,
  output entry_t q
);

  // Hold the entry until a new one is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_decode_skid.sv
// Fetch->decode 2-entry skid buffer with flush.
// Optional perf counters: define FETCH_DECODE_PERF_EN.
module fetch_decode_skid
  import fetch_decode_pkg::*;
#(
  parameter int XLEN = ENTRY_W,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_fetch_valid,
  output logic            o_fetch_ready,
  input  logic [XLEN-1:0] i_fetch_instr,
  input  logic [XLEN-1:0] i_fetch_pc,
  input  logic [XLEN-1:0] i_fetch_pc_plus4,
  input  logic            i_flush,
  output logic            o_id_valid,
  input  logic            i_id_ready,
  output logic [XLEN-1:0] o_id_instr,
  output logic [XLEN-1:0] o_id_pc,
  output logic [XLEN-1:0] o_id_pc_plus4,
  output logic [31:0]     o_stall_cycles,
  output logic [31:0]     o_flush_count
);

  occ_t   state;
  occ_t   state_d;
  entry_t in_ent;
  entry_t head_q;
  entry_t skid_q;
  entry_t head_d;
  logic   head_ld;
  logic   skid_ld;
  logic   accept;
  logic   consume;

  assign in_ent = '{
    instr:    i_fetch_instr,
    pc:       i_fetch_pc,
    pc_plus4: i_fetch_pc_plus4
  };

  // Ready/valid are pure decodes of the
  // occupancy register: no path from i_id_ready.
  assign o_fetch_ready = (state != TWO);
  assign o_id_valid    = (state != EMPTY);

  assign accept  = i_fetch_valid & o_fetch_ready;
  assign consume = o_id_valid & i_id_ready;

  // Next occupancy and slot loads; flush wins.
  always_comb begin
    state_d = state;
    head_d  = in_ent;
    head_ld = 1'b0;
    skid_ld = 1'b0;
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            head_ld = 1'b1;
          end
        end
        ONE: begin
          unique case (1'b1)
            accept & consume: begin
              head_ld = 1'b1;
            end
            accept & ~consume: begin
              state_d = TWO;
              skid_ld = 1'b1;
            end
            ~accept & consume: begin
              state_d = EMPTY;
            end
            default: begin
              state_d = ONE;
            end
          endcase
        end
        TWO: begin
          if (consume) begin
            state_d = ONE;
            head_d  = skid_q;
            head_ld = 1'b1;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Occupancy register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= EMPTY;
    end else begin
      state <= state_d;
    end
  end

  if_entry_reg u_head (
    .clk   (i_clk),
    .rst_n (i_rst),
    .load  (head_ld),
    .d     (head_d),
    .q     (head_q)
  );

  if_entry_reg u_skid (
    .clk   (i_clk),
    .rst_n (i_rst),
    .load  (skid_ld),
    .d     (in_ent),
    .q     (skid_q)
  );

  assign o_id_instr    = o_id_valid ? head_q.instr
                                    : NOP_INSTR;
  assign o_id_pc       = head_q.pc;
  assign o_id_pc_plus4 = head_q.pc_plus4;

`ifdef FETCH_DECODE_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // Stall and flush event counters, free-wrapping.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (o_id_valid & ~i_id_ready) begin
        stall_q <= stall_q + 32'd1;
      end
      if (i_flush) begin
        flush_q <= flush_q + 32'd1;
      end
    end
  end

  assign o_stall_cycles = stall_q;
  assign o_flush_count  = flush_q;
`else
  assign o_stall_cycles = '0;
  assign o_flush_count  = '0;
`endif

endmodule

// File: tb/tb_fetch_decode_skid.sv
// Scoreboard bench for fetch_decode_skid.
// Driver pushes accepted entries; monitor pops on consume.
module tb_fetch_decode_skid;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_fetch_valid = 1'b0;
  logic        o_fetch_ready;
  logic [31:0] i_fetch_instr = '0;
  logic [31:0] i_fetch_pc = '0;
  logic [31:0] i_fetch_pc_plus4 = '0;
  logic        i_flush = 1'b0;
  logic        o_id_valid;
  logic        i_id_ready = 1'b0;
  logic [31:0] o_id_instr;
  logic [31:0] o_id_pc;
  logic [31:0] o_id_pc_plus4;
  logic [31:0] o_stall_cycles;
  logic [31:0] o_flush_count;

  int   vectors = 0;
  int   miscompares = 0;
  vec_t sb[$];

  fetch_decode_skid dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_fetch_valid    (i_fetch_valid),
    .o_fetch_ready    (o_fetch_ready),
    .i_fetch_instr    (i_fetch_instr),
    .i_fetch_pc       (i_fetch_pc),
    .i_fetch_pc_plus4 (i_fetch_pc_plus4),
    .i_flush          (i_flush),
    .o_id_valid       (o_id_valid),
    .i_id_ready       (i_id_ready),
    .o_id_instr       (o_id_instr),
    .o_id_pc          (o_id_pc),
    .o_id_pc_plus4    (o_id_pc_plus4),
    .o_stall_cycles   (o_stall_cycles),
    .o_flush_count    (o_flush_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Monitor: pop and compare each delivered entry.
  always @(negedge i_clk) begin
    if (i_rst && o_id_valid && i_id_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out: got pc %h expected none",
                 o_id_pc);
      end else begin
        vec_t e;
        e = sb.pop_front();
        chk("out_instr", o_id_instr, e.instr);
        chk("out_pc", o_id_pc, e.pc);
        chk("out_pc4", o_id_pc_plus4, e.pc4);
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Offer one entry for one cycle; record it if taken.
  task automatic offer(input vec_t v, input bit fl,
                       output bit acc);
    i_fetch_valid    = 1'b1;
    i_fetch_instr    = v.instr;
    i_fetch_pc       = v.pc;
    i_fetch_pc_plus4 = v.pc4;
    i_flush          = fl;
    acc = o_fetch_ready && !fl;
    if (acc) sb.push_back(v);
    step();
    i_fetch_valid = 1'b0;
    i_flush       = 1'b0;
    if (fl) sb.delete();
  endtask

  vec_t v0   = '{32'h00500093, 32'h00000000, 32'h00000004};
  vec_t v4   = '{32'h00a00113, 32'h00000004, 32'h00000008};
  vec_t v8   = '{32'h002081b3, 32'h00000008, 32'h0000000c};
  vec_t v10  = '{32'h00100213, 32'h00000010, 32'h00000014};
  vec_t v14  = '{32'h00200293, 32'h00000014, 32'h00000018};
  vec_t v18  = '{32'h00300313, 32'h00000018, 32'h0000001c};
  vec_t v20  = '{32'h00400393, 32'h00000020, 32'h00000024};
  vec_t v24  = '{32'h00500413, 32'h00000024, 32'h00000028};
  vec_t v30  = '{32'h00600493, 32'h00000030, 32'h00000034};
  vec_t v40  = '{32'h0000006f, 32'h00000040, 32'h00000044};
  vec_t v50  = '{32'h00700513, 32'h00000050, 32'h00000054};
  vec_t v100 = '{32'h00800593, 32'h00000100, 32'h00000104};

  initial begin
    bit acc;
    bit got;
    #3;
    chk("rst_valid", {31'd0, o_id_valid}, 32'd0);
    chk("rst_instr", o_id_instr, NOP);
    chk("rst_ready", {31'd0, o_fetch_ready}, 32'd1);
    chk("rst_stall", o_stall_cycles, 32'd0);
    chk("rst_flush", o_flush_count, 32'd0);
    #9 i_rst = 1'b1;
    step();

    // Steady flow, one-cycle latency.
    i_id_ready = 1'b1;
    offer(v0, 1'b0, acc);
    chk("flow_acc0", {31'd0, acc}, 32'd1);
    chk("flow_pc0", o_id_pc, 32'h0);
    chk("flow_rdy0", {31'd0, o_fetch_ready}, 32'd1);
    offer(v4, 1'b0, acc);
    chk("flow_pc4", o_id_pc, 32'h4);
    chk("flow_rdy4", {31'd0, o_fetch_ready}, 32'd1);
    offer(v8, 1'b0, acc);
    chk("flow_pc8", o_id_pc, 32'h8);
    chk("flow_rdy8", {31'd0, o_fetch_ready}, 32'd1);
    step();
    chk("flow_empty", {31'd0, o_id_valid}, 32'd0);

    // Decode stall fills the skid slot.
    i_id_ready = 1'b0;
    offer(v10, 1'b0, acc);
    offer(v14, 1'b0, acc);
    chk("stall_rdy", {31'd0, o_fetch_ready}, 32'd0);
    chk("stall_head", o_id_pc, 32'h10);
    offer(v18, 1'b0, acc);
    chk("stall_rej18", {31'd0, acc}, 32'd0);
    chk("stall_head2", o_id_pc, 32'h10);
    i_id_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      offer(v18, 1'b0, acc);
      got = acc;
    end
    chk("stall_acc18", {31'd0, got}, 32'd1);
    step();
    chk("stall_drain", {31'd0, o_id_valid}, 32'd0);

    // Flush from TWO while offering pc 0x40.
    i_id_ready = 1'b0;
    offer(v20, 1'b0, acc);
    offer(v24, 1'b0, acc);
    step();
    chk("two_rdy", {31'd0, o_fetch_ready}, 32'd0);
    offer(v40, 1'b1, acc);
    chk("fl_valid", {31'd0, o_id_valid}, 32'd0);
    chk("fl_instr", o_id_instr, NOP);
    chk("fl_ready", {31'd0, o_fetch_ready}, 32'd1);
    i_id_ready = 1'b1;
    step();
    step();

    // Flush while decode consumes the head.
    offer(v30, 1'b0, acc);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    sb.delete();
    chk("fl2_valid", {31'd0, o_id_valid}, 32'd0);
    chk("fl2_ready", {31'd0, o_fetch_ready}, 32'd1);

`ifdef FETCH_DECODE_PERF_EN
    chk("perf_stall", o_stall_cycles, 32'd5);
    chk("perf_flush", o_flush_count, 32'd2);
`else
    chk("perf_stall", o_stall_cycles, 32'd0);
    chk("perf_flush", o_flush_count, 32'd0);
`endif

    // Asynchronous reset mid-cycle while in ONE.
    i_id_ready = 1'b0;
    offer(v50, 1'b0, acc);
    chk("one_valid", {31'd0, o_id_valid}, 32'd1);
    #1 i_rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, o_id_valid}, 32'd0);
    chk("arst_ready", {31'd0, o_fetch_ready}, 32'd1);
    chk("arst_instr", o_id_instr, NOP);
    chk("arst_stall", o_stall_cycles, 32'd0);
    sb.delete();
    @(negedge i_clk);
    #1 i_rst = 1'b1;
    step();
    i_id_ready = 1'b1;
    offer(v100, 1'b0, acc);
    chk("post_acc", {31'd0, acc}, 32'd1);
    chk("post_pc", o_id_pc, 32'h100);
    chk("post_instr", o_id_instr, 32'h00800593);
    step();
    step();
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
